target_scheduler: RTL

//   Consumer of the 18-bit LFSR counter. Requests a fresh random_value
//   (change pulse), reduces it to one LED index 0..NUM_LEDS-1 (never the

---
 rtl/target_scheduler_pkg.sv | 16 +
 rtl/target_scheduler_if.sv | 23 ++
 rtl/target_scheduler_down_timer.sv | 19 +
 rtl/target_scheduler.sv | 111 +++++++++++
 4 files changed

// File: rtl/target_scheduler_pkg.sv
// target_scheduler_pkg: shared widths, FSM state encoding and saturating increment
package target_scheduler_pkg;
  localparam int NUM_LEDS_DEF = 18;
  localparam int RNG_W = 18;
  localparam int HITS_W = 8;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_PICK = 3'd2,
    S_SHOW = 3'd3,
    S_GAP  = 3'd4
  } state_e;
  function automatic logic [HITS_W-1:0] sat_inc(input logic [HITS_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/target_scheduler_if.sv
// target_scheduler_if: game-side bus of the scheduler
//   enable, random_value, hit_in -> scheduler; change, led_out, hit_pulse, miss_pulse, hits <- scheduler
//   master: scheduler view; slave: environment view
interface target_scheduler_if import target_scheduler_pkg::*; #(
  parameter int NUM_LEDS = NUM_LEDS_DEF
);
  logic                enable;
  logic [RNG_W-1:0]    random_value;
  logic                change;
  logic [NUM_LEDS-1:0] hit_in;
  logic [NUM_LEDS-1:0] led_out;
  logic                hit_pulse;
  logic                miss_pulse;
  logic [HITS_W-1:0]   hits;
  modport master (
    input  enable, random_value, hit_in,
    output change, led_out, hit_pulse, miss_pulse, hits
  );
  modport slave (
    output enable, random_value, hit_in,
    input  change, led_out, hit_pulse, miss_pulse, hits
  );
endinterface

// File: rtl/target_scheduler_down_timer.sv
// target_scheduler_down_timer: loadable down counter with zero flag
//   clk_i, rst_ni (async low) | load_i/value_i load, dec_i decrements (stops at 0) | zero_o count==0
module target_scheduler_down_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? value_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/target_scheduler.sv
// target_scheduler: picks a random LED (never the previous one), lights it, scores hit/miss
//   clk_i, rst_ni (async low) | bus.master: enable/random_value/hit_in in,
//   change/led_out/hit_pulse/miss_pulse/hits out (all registered)
module target_scheduler import target_scheduler_pkg::*; #(
  parameter int NUM_LEDS   = NUM_LEDS_DEF,
  parameter int ON_CYCLES  = 50_000_000,
  parameter int GAP_CYCLES = 10_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  target_scheduler_if.master bus
);
  localparam int IW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
  localparam int TW = $clog2(ON_CYCLES > GAP_CYCLES ? ON_CYCLES : GAP_CYCLES);
  state_e              state_q, state_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                change_q, change_d;
  logic                hit_q, hit_d;
  logic                miss_q, miss_d;
  logic [HITS_W-1:0]   hits_q, hits_d;
  logic [IW-1:0]       prev_q, prev_d;
  logic [IW-1:0]       raw_idx, pick_idx;
  logic                t_load, t_dec, t_zero;
  logic [TW-1:0]       t_val;
  // Reduce the random value, then step past the previous index so a target never repeats
  assign raw_idx  = IW'(bus.random_value % RNG_W'(NUM_LEDS));
  assign pick_idx = raw_idx != prev_q ? raw_idx : raw_idx == IW'(NUM_LEDS - 1) ? '0 : raw_idx + 1'b1;
  // PICK loads the lit interval, leaving SHOW loads the dark interval
  assign t_val = state_q == S_PICK ? TW'(ON_CYCLES - 1) : TW'(GAP_CYCLES - 1);
  target_scheduler_down_timer #(.W(TW)) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (t_load),
    .value_i(t_val),
    .dec_i  (t_dec),
    .zero_o (t_zero)
  );
  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    change_d = 1'b0;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    hits_d   = hits_q;
    prev_d   = prev_q;
    t_load   = 1'b0;
    t_dec    = 1'b0;
    if (!bus.enable) begin
      state_d = S_IDLE;
      led_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_REQ;
          change_d = 1'b1;
        end
        S_REQ: state_d = S_PICK;
        S_PICK: begin
          state_d = S_SHOW;
          led_d   = {{(NUM_LEDS - 1){1'b0}}, 1'b1} << pick_idx;
          prev_d  = pick_idx;
          t_load  = 1'b1;
        end
        S_SHOW: begin
          if (bus.hit_in[prev_q]) begin
            state_d = S_GAP;
            led_d   = '0;
            hit_d   = 1'b1;
            hits_d  = sat_inc(hits_q);
            t_load  = 1'b1;
          end else if (t_zero) begin
            state_d = S_GAP;
            led_d   = '0;
            miss_d  = 1'b1;
            t_load  = 1'b1;
          end else t_dec = 1'b1;
        end
        S_GAP: begin
          if (t_zero) begin
            state_d  = S_REQ;
            change_d = 1'b1;
          end else t_dec = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      led_q    <= '0;
      change_q <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      hits_q   <= '0;
      prev_q   <= IW'(NUM_LEDS - 1);
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      change_q <= change_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      hits_q   <= hits_d;
      prev_q   <= prev_d;
    end
  assign bus.led_out    = led_q;
  assign bus.change     = change_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.hits       = hits_q;
endmodule
